keypad_emulator: RTL and testbench

Drives a 4x4 key-matrix column interface the way a physical keypad would, so that a row-scanning keypad encoder can be exercised and looped back on-chip. Key codes are pushed into a small FIFO through a valid/ready handshake. The block then "presses" each key in turn for a programmable hold time, followed by a programmable release gap. While a key is pressed, the block pulls the matching column low whenever the scanner strobes that key's row.

---
 rtl/keypad_emulator.sv | 123 ++++++++++++
 tb/tb_keypad_emulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Emulates a 4x4 key matrix: queued key codes are pressed one at a time for
// HOLD_CYCLES, released for GAP_CYCLES, and answered on the column lines.
module keypad_emulator #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    key_code,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic                          flush,
  input  logic [3:0]                    rows_in,
  output logic [3:0]                    cols_out,
  output logic                          pressed,
  output logic [3:0]                    cur_key,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, next_state;
  logic [15:0]        cnt_q, cnt_d;
  logic [3:0]         cur_key_q;
  logic [3:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               push, pop;

  assign key_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = key_valid & key_ready & ~flush;
  assign pressed    = (state_q == PRESS);
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign cur_key    = cur_key_q;
  assign fifo_count = count_q;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= key_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_key_q <= '0;
    end else begin
      state_q <= next_state;
      cnt_q   <= cnt_d;
      if (pop) cur_key_q <= mem[rd_ptr_q];
    end
  end

  // A single down-counter times both the hold and the release gap.
  always_comb begin
    next_state = state_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    if (flush) begin
      next_state = IDLE;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            pop        = 1'b1;
            cnt_d      = 16'(HOLD_CYCLES - 1);
            next_state = PRESS;
          end
        end
        PRESS: begin
          if (cnt_q == '0) begin
            cnt_d      = 16'(GAP_CYCLES - 1);
            next_state = GAP;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == '0) next_state = IDLE;
          else             cnt_d = cnt_q - 16'd1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Unregistered so the scanner sees the column within its own strobe cycle.
  always_comb begin
    cols_out = 4'hF;
    if (pressed && !rows_in[cur_key_q[3:2]]) cols_out[cur_key_q[1:0]] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator, including a loopback
// row scanner that decodes the emulated key presses.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       flush;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  logic       pressed;
  logic [3:0] cur_key;
  logic       busy;
  logic [2:0] fifo_count;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int base        = 0;

  logic [3:0] manual_rows = 4'hF;
  logic       scan_en     = 1'b0;
  logic [1:0] scan_row    = 2'd0;
  logic       sweep_hit   = 1'b0;
  logic       prev_hit    = 1'b0;
  logic [3:0] sweep_code  = 4'd0;
  logic [3:0] det_q [$];
  logic       hit_now;
  logic [3:0] hit_code_now;

  keypad_emulator #(.HOLD_CYCLES(16), .GAP_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .flush(flush), .rows_in(rows_in), .cols_out(cols_out),
    .pressed(pressed), .cur_key(cur_key), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Loopback scanner: one row per cycle, a key is reported on the first
  // sweep that sees it after a sweep that saw nothing.
  function automatic logic [1:0] col_of(input logic [3:0] c);
    if (!c[0])      col_of = 2'd0;
    else if (!c[1]) col_of = 2'd1;
    else if (!c[2]) col_of = 2'd2;
    else            col_of = 2'd3;
  endfunction

  assign rows_in      = scan_en ? ~(4'b0001 << scan_row) : manual_rows;
  assign hit_now      = (cols_out != 4'hF);
  assign hit_code_now = hit_now ? {scan_row, col_of(cols_out)} : sweep_code;

  always @(posedge clk) scan_row <= scan_en ? scan_row + 2'd1 : 2'd0;

  always @(negedge clk) begin
    if (!scan_en) begin
      sweep_hit <= 1'b0;
      prev_hit  <= 1'b0;
    end else if (scan_row == 2'd3) begin
      if ((sweep_hit || hit_now) && !prev_hit) det_q.push_back(hit_code_now);
      prev_hit  <= sweep_hit || hit_now;
      sweep_hit <= 1'b0;
    end else if (hit_now) begin
      sweep_hit  <= 1'b1;
      sweep_code <= hit_code_now;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits until the negedge following push-relative edge e.
  task automatic wait_edge(input int e);
    while (cycle < base + 1 + e) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    int n;
    key_code  = code;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("push_timeout", 32'(key_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; key_code = 4'd0; key_valid = 1'b0; flush = 1'b0;
    #12;
    checkOutput("rst_cols", 32'(cols_out), 32'hF);
    checkOutput("rst_ready", 32'(key_ready), 32'd1);
    checkOutput("rst_pressed", 32'(pressed), 32'd0);
    checkOutput("rst_cur_key", 32'(cur_key), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] idle row sweep");
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      manual_rows = ~(4'b0001 << r);
      #1 checkOutput("idle_cols", 32'(cols_out), 32'hF);
    end
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_ready", 32'(key_ready), 32'd1);

    $display("[TB] single key 6");
    @(negedge clk);
    key_code = 4'h6; key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    #1 checkOutput("single_count", 32'(fifo_count), 32'd1);
    checkOutput("single_not_yet", 32'(pressed), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      manual_rows = (i == 5) ? 4'b0000 : ~(4'b0001 << (i % 4));
      #1 checkOutput("hold_pressed", 32'(pressed), 32'd1);
      checkOutput("hold_cols", 32'(cols_out), (manual_rows[1] == 1'b0) ? 32'hB : 32'hF);
    end
    checkOutput("hold_cur_key", 32'(cur_key), 32'h6);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      manual_rows = 4'b1101;
      #1 checkOutput("gap_pressed", 32'(pressed), 32'd0);
      checkOutput("gap_cols", 32'(cols_out), 32'hF);
      checkOutput("gap_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    #1 checkOutput("after_gap_busy", 32'(busy), 32'd0);

    $display("[TB] FIFO full");
    base = cycle;
    for (int k = 0; k < 6; k++) begin
      key_code = 4'(k); key_valid = 1'b1;
      #1 checkOutput("full_ready", 32'(key_ready), (k < 5) ? 32'd1 : 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    key_valid = 1'b0;
    #1 checkOutput("full_count", 32'(fifo_count), 32'd4);
    checkOutput("full_first", 32'(cur_key), 32'd0);
    for (int e = 6; e <= 125; e++) begin
      wait_edge(e);
      #1;
      if (e == 25) checkOutput("full_ready_low", 32'(key_ready), 32'd0);
      if (e == 26) checkOutput("full_ready_back", 32'(key_ready), 32'd1);
      if (e == 26) checkOutput("full_count_pop", 32'(fifo_count), 32'd3);
      if ((e - 1) % 25 == 0) begin
        checkOutput("order_pressed", 32'(pressed), 32'd1);
        checkOutput("order_key", 32'(cur_key), 32'((e - 1) / 25));
      end
    end
    checkOutput("full_drained", 32'(busy), 32'd0);
    checkOutput("code5_refused", 32'(cur_key), 32'd4);

    $display("[TB] simultaneous push and pop");
    key_code = 4'd9; key_valid = 1'b1;
    wait_edge(126); key_code = 4'd10;
    wait_edge(127); key_code = 4'd11;
    #1 checkOutput("pp1_count", 32'(fifo_count), 32'd1);
    checkOutput("pp1_key", 32'(cur_key), 32'd9);
    wait_edge(128); key_valid = 1'b0;
    #1 checkOutput("pre2_count", 32'(fifo_count), 32'd2);
    wait_edge(151); key_code = 4'd12; key_valid = 1'b1;
    wait_edge(152); key_code = 4'd13;
    #1 checkOutput("pp2_count", 32'(fifo_count), 32'd2);
    checkOutput("pp2_key", 32'(cur_key), 32'd10);
    wait_edge(153); key_code = 4'd14;
    wait_edge(154); key_valid = 1'b0;
    #1 checkOutput("pre4_count", 32'(fifo_count), 32'd4);
    checkOutput("pre4_ready", 32'(key_ready), 32'd0);
    wait_edge(176); key_code = 4'd15; key_valid = 1'b1;
    wait_edge(177); key_valid = 1'b0;
    #1 checkOutput("pp4_refused", 32'(fifo_count), 32'd3);
    checkOutput("pp4_key", 32'(cur_key), 32'd11);

    $display("[TB] flush mid-press");
    manual_rows = 4'b1011;
    #1 checkOutput("preflush_cols", 32'(cols_out), 32'h7);
    wait_edge(180); flush = 1'b1; key_valid = 1'b1; key_code = 4'd5;
    wait_edge(181); flush = 1'b0; key_valid = 1'b0;
    #1 checkOutput("flush_pressed", 32'(pressed), 32'd0);
    checkOutput("flush_cols", 32'(cols_out), 32'hF);
    checkOutput("flush_count", 32'(fifo_count), 32'd0);
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_cur_key", 32'(cur_key), 32'd11);
    manual_rows = 4'hF;

    $display("[TB] loopback through scanner");
    @(negedge clk);
    scan_en = 1'b1;
    for (int k = 0; k < 16; k++) applyStimulus(4'(k));
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("loop_timeout", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("loop_size", 32'(det_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < det_q.size()) checkOutput("loop_key", 32'(det_q[i]), 32'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
